// File: rtl/prio_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prio_irq_pkg
//  Brief    : Shared types and index helpers for the priority interrupt block.
//  Revision : 1.0
// ============================================================================
package prio_irq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARB     = 2'd1,
      PRESENT = 2'd2
   } state_t;

   // Flat request index of channel c on bus b.
   function automatic int flat_idx(input int b, input int c, input int num_ch);
      return b * num_ch + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prio_irq_arb.sv
`default_nettype none
// ============================================================================
//  Module   : prio_irq_arb
//  Brief    : Combinational fixed-priority finder; lowest bus, then lowest channel.
//  Revision : 1.0
// ============================================================================
module prio_irq_arb
   import prio_irq_pkg::*;
#(
   parameter int NUM_BUS = 3,
   parameter int NUM_CH  = 9,
   parameter int BUS_W   = 2,
   parameter int CH_W    = 4
)(
   input  logic [NUM_BUS*NUM_CH-1:0] eligible,
   output logic                      found,
   output logic [BUS_W-1:0]          bus,
   output logic [CH_W-1:0]           chan
);

   // Scan from lowest priority upward so the last hit is the winner.
   always_comb begin
      found = 1'b0;
      bus   = '0;
      chan  = '0;
      for (int b = NUM_BUS - 1; b >= 0; b--) begin
         for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (eligible[flat_idx(b, c, NUM_CH)]) begin
               found = 1'b1;
               bus   = BUS_W'(b);
               chan  = CH_W'(c);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/prio_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prio_irq_ctrl
//  Brief    : Latched, masked, fixed-priority interrupt controller with valid/ack.
//  Revision : 1.0
// ============================================================================
module prio_irq_ctrl
   import prio_irq_pkg::*;
#(
   parameter int NUM_BUS   = 3,
   parameter int NUM_CH    = 9,
   parameter int EDGE_MODE = 1,
   parameter int BUS_W     = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_BUS*NUM_CH-1:0] req,
   input  logic                      cfg_we,
   input  logic [NUM_BUS*NUM_CH-1:0] cfg_mask,
   output logic                      irq_valid,
   input  logic                      irq_ack,
   output logic [BUS_W-1:0]          irq_bus,
   output logic [CH_W-1:0]           irq_chan,
   output logic [NUM_BUS*NUM_CH-1:0] pend_o,
   output logic                      ovr_o,
   input  logic                      ovr_clr
);

   localparam int c_num_src = NUM_BUS * NUM_CH;

   state_t                 r_state;
   logic                   r_valid;
   logic [BUS_W-1:0]       r_bus;
   logic [CH_W-1:0]        r_chan;
   logic [c_num_src-1:0]   r_req_q;
   logic [c_num_src-1:0]   r_pend;
   logic [c_num_src-1:0]   r_mask;
   logic                   r_ovr;

   logic                   w_ack_take;
   logic [c_num_src-1:0]   w_clr;
   logic [c_num_src-1:0]   w_eligible;
   logic [c_num_src-1:0]   w_pend_nxt;
   logic                   w_ovr_hit;
   logic                   w_found;
   logic [BUS_W-1:0]       w_bus;
   logic [CH_W-1:0]        w_chan;

   assign w_ack_take = (r_state == PRESENT) && irq_ack;
   assign w_eligible = r_pend & r_mask;

   // One-hot clear of the source currently being acknowledged.
   always_comb begin
      w_clr = '0;
      for (int b = 0; b < NUM_BUS; b++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            w_clr[flat_idx(b, c, NUM_CH)] = w_ack_take
                                           && (r_bus == BUS_W'(b))
                                           && (r_chan == CH_W'(c));
         end
      end
   end

   generate
      if (EDGE_MODE != 0) begin : g_edge
         logic [c_num_src-1:0] w_set;
         assign w_set      = req & ~r_req_q;
         // A new edge beats a same-cycle clear, and is not an overrun then.
         assign w_pend_nxt = (r_pend & ~w_clr) | w_set;
         assign w_ovr_hit  = |(w_set & r_pend & ~w_clr);
      end else begin : g_level
         assign w_pend_nxt = req;
         assign w_ovr_hit  = 1'b0;
      end
   endgenerate

   prio_irq_arb #(
      .NUM_BUS (NUM_BUS),
      .NUM_CH  (NUM_CH),
      .BUS_W   (BUS_W),
      .CH_W    (CH_W)
   ) u_arb (
      .eligible (w_eligible),
      .found    (w_found),
      .bus      (w_bus),
      .chan     (w_chan)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_q <= '0;
         r_pend  <= '0;
         r_mask  <= '1;
         r_ovr   <= 1'b0;
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_bus   <= '0;
         r_chan  <= '0;
      end else begin
         r_req_q <= req;
         r_pend  <= w_pend_nxt;
         if (cfg_we) begin
            r_mask <= cfg_mask;
         end
         if (w_ovr_hit) begin
            r_ovr <= 1'b1;
         end else if (ovr_clr) begin
            r_ovr <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_bus   <= w_bus;
                  r_chan  <= w_chan;
                  r_state <= ARB;
               end
            end
            ARB: begin
               r_valid <= 1'b1;
               r_state <= PRESENT;
            end
            PRESENT: begin
               if (irq_ack) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign irq_valid = r_valid;
   assign irq_bus   = r_bus;
   assign irq_chan  = r_chan;
   assign pend_o    = r_pend;
   assign ovr_o     = r_ovr;

endmodule
`default_nettype wire
